// File: rtl/rv32_pkg.sv
// RV32I opcode constants and instruction-format classification shared by the
// decoder, immediate generator and encode loader.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } fmt_e;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    case (op)
      OP_R:                                  return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   return FMT_I;
      OP_STORE:                              return FMT_S;
      OP_BRANCH:                             return FMT_B;
      OP_LUI, OP_AUIPC:                      return FMT_U;
      OP_JAL:                                return FMT_J;
      default:                               return FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_encode_loader_if.sv
// Field-bundle input handshake and IMEM write port of the encode loader.
interface instr_encode_loader_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [6:0]        funct7;
  logic [31:0]       immediate;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport master (
    output in_valid, opcode, rd, funct3, rs1, rs2, funct7, immediate, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, opcode, rd, funct3, rs1, rs2, funct7, immediate, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push on a full FIFO is accepted when a pop happens in
// the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/instr_encode_loader.sv
// Packs RV32I field bundles into instruction words and streams them into IMEM
// from a programmable base address through a stage register and FIFO.
module instr_encode_loader
  import rv32_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic [ADDR_W-1:0]    base_addr,
  instr_encode_loader_if.slave bus,
  output logic                 err_illegal,
  output logic [7:0]           illegal_cnt,
  output logic [CNT_W-1:0]     written_cnt,
  output logic                 idle
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [31:0] encode(
    input fmt_e        f,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [2:0]  f3,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    case (f)
      FMT_R:   return {f7, rs2, rs1, f3, rd, op};
      FMT_I:   return {imm[11:0], rs1, f3, rd, op};
      FMT_S:   return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      FMT_B:   return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      FMT_U:   return {imm[31:12], rd, op};
      FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: return '0;
    endcase
  endfunction

  fmt_e              fmt;
  logic [31:0]       enc_word;
  logic              accept;
  logic              legal;
  logic              pop;
  logic              stage_valid;
  logic [31:0]       stage_word;
  logic [ADDR_W-1:0] wr_addr;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  logic [31:0]       fifo_head;

  always_comb begin
    fmt      = opcode_fmt(bus.opcode);
    enc_word = encode(fmt, bus.opcode, bus.rd, bus.funct3, bus.rs1, bus.rs2,
                      bus.funct7, bus.immediate);
  end

  // The stage register counts toward occupancy so a full FIFO can always take
  // the staged word on the following edge.
  assign occupancy    = {1'b0, fifo_count} + {{CW{1'b0}}, stage_valid};
  assign bus.in_ready = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = (fmt != FMT_ILL);
  assign bus.mem_we   = !fifo_empty;
  assign bus.mem_wdata = fifo_head;
  assign bus.mem_addr = wr_addr;
  assign pop          = bus.mem_we && bus.mem_ready;
  assign idle         = !stage_valid && fifo_empty;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_valid),
    .pop   (pop),
    .din   (stage_word),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_word  <= '0;
      err_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      stage_valid <= accept && legal;
      if (accept && legal) stage_word <= enc_word;
      err_illegal <= accept && !legal;
      if (accept && !legal && illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_addr     <= '0;
      written_cnt <= '0;
    end else if (load_start && idle) begin
      wr_addr     <= {base_addr[ADDR_W-1:2], 2'b00};
      written_cnt <= '0;
    end else if (pop) begin
      wr_addr     <= wr_addr + ADDR_W'(4);
      written_cnt <= written_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: encoding table, pipeline timing,
// backpressure, illegal opcodes, address wrap, load_start gating and reset.
module tb_instr_encode_loader;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [11:0] base_addr;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;
  logic [15:0] written_cnt;
  logic        idle;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;
  logic ready_drop;

  logic [11:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_cyc[$];

  vec_t tbl[6];
  vec_t v;

  instr_encode_loader_if #(.ADDR_W(12)) bus ();

  instr_encode_loader #(
    .FIFO_DEPTH (4),
    .ADDR_W     (12),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .base_addr   (base_addr),
    .bus         (bus.slave),
    .err_illegal (err_illegal),
    .illegal_cnt (illegal_cnt),
    .written_cnt (written_cnt),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (!rst && bus.mem_we && bus.mem_ready) begin
      wq_addr.push_back(bus.mem_addr);
      wq_data.push_back(bus.mem_wdata);
      wq_cyc.push_back(cycle);
    end
    if (!bus.in_ready) ready_drop = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input vec_t x);
    bus.opcode    = x.op;
    bus.rd        = x.rd;
    bus.funct3    = x.f3;
    bus.rs1       = x.rs1;
    bus.rs2       = x.rs2;
    bus.funct7    = x.f7;
    bus.immediate = x.imm;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t x);
    int n;
    drive(x);
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wq_data.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("write_count", wq_data.size(), n);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!idle && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_wait", {31'd0, idle}, 32'd1);
  endtask

  task automatic pulse_load(input logic [11:0] b);
    load_start = 1'b1;
    base_addr  = b;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  function automatic vec_t addi(input int i);
    vec_t r;
    r.op  = 7'h13;
    r.rd  = 5'(i);
    r.f3  = 3'd0;
    r.rs1 = 5'd0;
    r.rs2 = 5'd31;
    r.f7  = 7'h55;
    r.imm = 32'(i);
    r.word = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
    return r;
  endfunction

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"},    {31'd0, bus.in_ready},  32'd1);
    check({tag, "_mem_we"},      {31'd0, bus.mem_we},    32'd0);
    check({tag, "_mem_addr"},    {20'd0, bus.mem_addr},  32'd0);
    check({tag, "_mem_wdata"},   bus.mem_wdata,          32'd0);
    check({tag, "_err_illegal"}, {31'd0, err_illegal},   32'd0);
    check({tag, "_illegal_cnt"}, {24'd0, illegal_cnt},   32'd0);
    check({tag, "_written_cnt"}, {16'd0, written_cnt},   32'd0);
    check({tag, "_idle"},        {31'd0, idle},          32'd1);
  endtask

  initial begin
    //            op      rd     f3    rs1    rs2    f7      imm            word
    tbl[0] = '{7'h33, 5'd3, 3'd0, 5'd1, 5'd2,  7'h00, 32'h0000_0000, 32'h002081B3};
    tbl[1] = '{7'h23, 5'd9, 3'd2, 5'd1, 5'd2,  7'h7F, 32'h0000_0008, 32'h0020A423};
    tbl[2] = '{7'h63, 5'd0, 3'd0, 5'd1, 5'd2,  7'h00, 32'hFFFF_FFFC, 32'hFE208EE3};
    tbl[3] = '{7'h6F, 5'd1, 3'd7, 5'd7, 5'd9,  7'h7F, 32'h0000_0008, 32'h008000EF};
    tbl[4] = '{7'h37, 5'd5, 3'd3, 5'd4, 5'd31, 7'h11, 32'h1234_5000, 32'h123452B7};
    tbl[5] = '{7'h03, 5'd5, 3'd2, 5'd2, 5'd0,  7'h00, 32'hFFFF_FFF8, 32'hFF812283};

    rst = 1'b1;
    load_start = 1'b0;
    base_addr = '0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b1;
    drive(tbl[0]);
    ready_drop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single addi: latency and first write.
    pulse_load(12'h100);
    v = addi(0);
    v.rd = 5'd1; v.imm = 32'd5; v.word = 32'h00500093;
    send(v);
    check("stage_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("stage_idle",   {31'd0, idle},       32'd0);
    @(posedge clk);
    #1;
    check("first_mem_we",    {31'd0, bus.mem_we},   32'd1);
    check("first_mem_addr",  {20'd0, bus.mem_addr}, 32'h100);
    check("first_mem_wdata", bus.mem_wdata,         32'h00500093);
    @(posedge clk);
    #1;
    check("first_written_cnt", {16'd0, written_cnt}, 32'd1);
    check("first_drained",     {31'd0, bus.mem_we},  32'd0);
    clear_q();

    // Encoding table, back-to-back at full throughput.
    pulse_load(12'h100);
    ready_drop = 1'b0;
    for (int i = 0; i < 6; i++) send(tbl[i]);
    wait_writes(6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq_data.size()) begin
        check($sformatf("tbl%0d_addr", i), {20'd0, wq_addr[i]}, 32'h100 + 32'(4 * i));
        check($sformatf("tbl%0d_data", i), wq_data[i], tbl[i].word);
        if (i > 0) check($sformatf("tbl%0d_gap", i), wq_cyc[i] - wq_cyc[i-1], 32'd1);
      end
    end
    check("tbl_ready_steady", {31'd0, ready_drop}, 32'd0);
    check("tbl_written_cnt",  {16'd0, written_cnt}, 32'd6);
    clear_q();

    // Backpressure: six bundles while IMEM stalls.
    bus.mem_ready = 1'b0;
    pulse_load(12'h200);
    ready_drop = 1'b0;
    fork
      begin
        for (int i = 1; i <= 6; i++) send(addi(i));
      end
      begin
        repeat (8) @(negedge clk);
        check("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        check("bp_mem_we",    {31'd0, bus.mem_we},   32'd1);
        check("bp_addr_hold", {20'd0, bus.mem_addr}, 32'h200);
        check("bp_data_hold", bus.mem_wdata,         addi(1).word);
        @(negedge clk);
        check("bp_addr_hold2", {20'd0, bus.mem_addr}, 32'h200);
        check("bp_data_hold2", bus.mem_wdata,         addi(1).word);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
      end
    join
    wait_writes(6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq_data.size()) begin
        check($sformatf("bp%0d_addr", i), {20'd0, wq_addr[i]}, 32'h200 + 32'(4 * i));
        check($sformatf("bp%0d_data", i), wq_data[i], addi(i + 1).word);
      end
    end
    check("bp_ready_dropped", {31'd0, ready_drop}, 32'd1);
    check("bp_written_cnt",   {16'd0, written_cnt}, 32'd6);
    clear_q();

    // Illegal opcode.
    wait_idle();
    v = addi(3);
    v.op = 7'h7F;
    send(v);
    check("ill_err_pulse", {31'd0, err_illegal}, 32'd1);
    check("ill_cnt1",      {24'd0, illegal_cnt}, 32'd1);
    check("ill_idle",      {31'd0, idle},        32'd1);
    @(posedge clk);
    #1;
    check("ill_err_clear", {31'd0, err_illegal},  32'd0);
    check("ill_no_we",     {31'd0, bus.mem_we},   32'd0);
    check("ill_addr_kept", {20'd0, bus.mem_addr}, 32'h218);
    check("ill_cnt_kept",  {16'd0, written_cnt},  32'd6);
    for (int i = 0; i < 256; i++) send(v);
    check("ill_saturate", {24'd0, illegal_cnt}, 32'd255);
    check("ill_no_writes", wq_data.size(), 32'd0);

    // load_start together with an accept, then address wrap.
    v = addi(0);
    v.op = 7'h17; v.rd = 5'd10; v.imm = 32'hFFFF_F000; v.word = 32'hFFFFF517;
    drive(v);
    bus.in_valid = 1'b1;
    load_start = 1'b1;
    base_addr = 12'hFFC;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    load_start = 1'b0;
    v.op = 7'h73; v.rd = 5'd0; v.imm = 32'd1; v.word = 32'h00100073;
    send(v);
    wait_writes(2);
    if (wq_data.size() >= 2) begin
      check("wrap0_addr", {20'd0, wq_addr[0]}, 32'hFFC);
      check("wrap0_data", wq_data[0],          32'hFFFFF517);
      check("wrap1_addr", {20'd0, wq_addr[1]}, 32'h000);
      check("wrap1_data", wq_data[1],          32'h00100073);
    end
    check("wrap_written_cnt", {16'd0, written_cnt}, 32'd2);
    clear_q();

    // load_start while busy is ignored.
    bus.mem_ready = 1'b0;
    send(addi(1));
    @(posedge clk);
    #1;
    check("busy_idle", {31'd0, idle}, 32'd0);
    pulse_load(12'h400);
    check("busy_addr", {20'd0, bus.mem_addr}, 32'h004);
    bus.mem_ready = 1'b1;
    wait_writes(1);
    if (wq_data.size() >= 1) check("busy_write_addr", {20'd0, wq_addr[0]}, 32'h004);
    check("busy_written_cnt", {16'd0, written_cnt}, 32'd3);
    clear_q();

    // Reset with words buffered.
    bus.mem_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send(addi(i));
    @(posedge clk);
    #1;
    check("rst_pre_we", {31'd0, bus.mem_we}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_no_we",     {31'd0, bus.mem_we}, 32'd0);
    check("post_rst_no_writes", wq_data.size(),      32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the instruction-field decoder: takes split RISC-V RV32I fields (opcode, rd, funct3, rs1, rs2, funct7, immediate) and packs them into 32-bit instruction words.
- Encoded words are buffered in a FIFO and written sequentially into instruction memory from a programmable base address.
- Used by the bring-up/test path to load programs into IMEM without an external assembler.

Parameters:
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2)
- ADDR_W, 12, byte-address width of the IMEM write port
- CNT_W, 16, width of the written-word counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- load_start  in  1  pulse: load wr_addr from base_addr (honoured only when idle)
- base_addr  in  ADDR_W  start byte address, word aligned
- in_valid  in  1  field bundle valid
- in_ready  out  1  block can accept a bundle
- opcode  in  7  instruction opcode
- rd  in  5  destination register
- funct3  in  3  funct3
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- funct7  in  7  funct7 (R-type only)
- immediate  in  32  full immediate as the decoder yields it: sign-extended byte offset; U-type already <<12
- mem_we  out  1  IMEM write request
- mem_addr  out  ADDR_W  IMEM byte address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  IMEM accepts write this cycle
- err_illegal  out  1  one-cycle pulse: accepted bundle had unsupported opcode
- illegal_cnt  out  8  saturating count of illegal bundles
- written_cnt  out  CNT_W  words written since last load_start (wraps)
- idle  out  1  stage register and FIFO empty

Behaviour:
- Reset: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, err_illegal=0, illegal_cnt=0, written_cnt=0, idle=1; FIFO, stage register and wr_addr cleared. Reset mid-transfer discards all buffered words; no further mem_we until new input.
- Accept: handshake on in_valid&in_ready. in_ready = (fifo_count + stage_valid) < FIFO_DEPTH; it never depends on in_valid.
- Encoding, by opcode:
  - R 0110011: funct7|rs2|rs1|f3|rd|op
  - I 0010011/0000011/1100111/1110011: imm[11:0]|rs1|f3|rd|op
  - S 0100011: imm[11:5]|rs2|rs1|f3|imm[4:0]|op
  - B 1100011: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op
  - U 0110111/0010111: imm[31:12]|rd|op
  - J 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
  - Fields a format does not use are ignored. Immediate bits outside the format are ignored, with no range check.
- Pipeline:
  - Accept edge N: encoded word captured into the stage register.
  - Edge N+1: stage pushed into the FIFO.
  - mem_we is high from edge N+1 onward. Throughput is 1 word/cycle when mem_ready=1.
- Illegal opcode: bundle is still accepted but the stage register is not loaded. err_illegal is high for the one cycle after the accept edge. illegal_cnt increments, saturating at 255.
- Write port: mem_we = FIFO not empty; mem_wdata = FIFO head; mem_addr = wr_addr. On mem_we&mem_ready:
  - pop the FIFO
  - wr_addr += 4, modulo 2^ADDR_W (wraps to 0)
  - written_cnt += 1
- mem_wdata and mem_addr hold stable while mem_we=1 and mem_ready=0.
- Push and pop in the same cycle leaves the count unchanged; this is legal when the FIFO is full.
- load_start: when idle=1, sets wr_addr=base_addr[ADDR_W-1:2]<<2 and written_cnt=0. When idle=0 it is ignored (no effect). If load_start and an input accept happen in the same cycle while idle, both take effect: the new word is written at base_addr.

Decomposition:
- Shared package rv32_pkg holds the opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL).
- rv32_pkg also holds the fmt_e enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL}, shared with the decoder and the immediate generator.
- Natural sub-module: sync_fifo (width 32, depth FIFO_DEPTH, push/pop/full/empty/count).
- The encoder is a combinational function inside the top-level module.

Test Plan:
- Reset, load_start with base_addr=0x100, send addi x1,x0,5 (op 0010011, rd 1, f3 0, rs1 0, imm 5) -> mem_we two cycles after accept, mem_addr=0x100, mem_wdata=0x00500093, written_cnt=1.
- Back-to-back with mem_ready=1:
  - add x3,x1,x2 -> 0x002081B3 at 0x100
  - sw x2,8(x1) -> 0x0020A423 at 0x104
  - beq x1,x2,imm=-4 -> 0xFE208EE3 at 0x108
  - Expect 1 word/cycle, in_ready never drops.
- jal x1,imm=8 -> 0x008000EF; lui x5,imm=0x12345000 -> 0x123452B7.
- Backpressure:
  - Hold mem_ready=0 and stream 6 bundles -> in_ready drops after FIFO_DEPTH words are in flight; mem_wdata/mem_addr stable.
  - Release mem_ready -> all words written in order, no loss or duplication.
- Illegal opcode 0x7F -> err_illegal one-cycle pulse, illegal_cnt=1, no mem_we, wr_addr unchanged. Then 256 illegals -> illegal_cnt=255.
- Edge cases:
  - base_addr=0xFFC with 2 words -> writes at 0xFFC then 0x000.
  - load_start while FIFO is non-empty -> ignored.
  - Assert rst with 3 words buffered -> mem_we=0 immediately and all outputs at reset values.
